// File: rtl/add_pipe.sv
// add_pipe: carry-pipelined adder/subtractor with a valid/ready handshake.
// The WIDTH-bit add is cut into STAGES slices of SW bits. Each stage adds one
// slice plus the carry from the stage before it. Each stage also carries the
// operand bits that are still to be added and the result bits already
// produced, so no carry path is longer than SW bits. The whole pipeline
// advances together whenever the output register is empty or being drained.

module add_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Global advance: the pipeline moves only when the result slot can be vacated.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtract is a + ~b + !cin, so the inverted borrow becomes the carry-in.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;

  for (genvar s = 0; s < STAGES; s++) begin : stage_g
    // REM counts the operand bits not yet summed, including this stage's slice.
    // DONE counts the result bits that exist once this stage has finished.
    localparam int REM  = WIDTH - s * SW;
    localparam int DONE = (s + 1) * SW;

    logic [REM-1:0]  a_d;
    logic [REM-1:0]  b_d;
    logic            c_d;
    logic            v_d;
    logic [SW:0]     slice;
    logic [DONE-1:0] sum_d;
    logic [DONE-1:0] sum_q;
    logic            c_q;
    logic            v_q;

    if (s == 0) begin : g_head
      assign a_d   = a;
      assign b_d   = b_eff;
      assign c_d   = c_eff;
      assign v_d   = in_valid && in_ready;
      assign sum_d = slice[SW-1:0];
    end else begin : g_body
      assign a_d   = stage_g[s-1].g_fwd.a_q;
      assign b_d   = stage_g[s-1].g_fwd.b_q;
      assign c_d   = stage_g[s-1].c_q;
      assign v_d   = stage_g[s-1].v_q;
      assign sum_d = {slice[SW-1:0], stage_g[s-1].sum_q};
    end

    // Only the lowest remaining slice is added here, so the carry ripple stays SW bits long.
    assign slice = {1'b0, a_d[SW-1:0]} + {1'b0, b_d[SW-1:0]} + {{SW{1'b0}}, c_d};

    // Valid bits move with the pipeline and are cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_d;
      end
    end

    // Partial sums and slice carries load only for real beats, so bubbles never reach sum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (adv && v_d) begin
        sum_q <= sum_d;
        c_q   <= slice[SW];
      end
    end

    if (s < LAST) begin : g_fwd
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] b_q;

      // The upper operand slices pass through unchanged for the stages that follow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_d) begin
          a_q <= a_d[REM-1:SW];
          b_q <= b_d[REM-1:SW];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // The last slice holds the MSBs, so signed overflow is resolved here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && v_d) begin
          ovf_q <= (a_d[SW-1] == b_d[SW-1]) && (slice[SW-1] != a_d[SW-1]);
        end
      end
    end
  end

  assign out_valid = stage_g[LAST].v_q;
  assign sum       = stage_g[LAST].sum_q;
  assign cout      = stage_g[LAST].c_q;
  assign ovf       = stage_g[LAST].g_tail.ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// tb_add_pipe: directed and random checks of add_pipe against an arithmetic model.
// The main instance uses WIDTH=16, STAGES=4. A second instance uses WIDTH=8,
// STAGES=1 and covers the single-stage case.

module tb_add_pipe;

  localparam int LAT = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cin8;
  logic        sub8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  sum8;
  logic        cout8;
  logic        ovf8;

  typedef struct {
    logic [15:0] s;
    bit          c;
    bit          o;
  } exp_t;

  exp_t q[$];

  int errors;
  int checks;
  int accCount;
  int outCount;

  bit          s_valid;
  logic [15:0] s_sum;
  bit          s_cout;
  bit          s_ovf;
  bit          s_inready;
  bit          s_cons;
  bit          s_acc;

  add_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  add_pipe #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .sub       (sub8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference arithmetic: unsigned sum for result/carry, signed range test for overflow.
  function automatic void model(input int w, input longint unsigned ua, input longint unsigned ub,
                                input bit ci, input bit sb,
                                output longint unsigned rs, output bit rc, output bit ro);
    longint unsigned mask;
    longint unsigned half;
    longint unsigned be;
    longint unsigned c;
    longint unsigned full;
    longint          sa;
    longint          se;
    longint          r;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    be   = sb ? (~ub & mask) : (ub & mask);
    c    = (sb ? !ci : ci) ? 64'd1 : 64'd0;
    full = (ua & mask) + be + c;
    rs   = full & mask;
    rc   = ((full >> w) & 64'd1) != 64'd0;
    sa   = longint'(ua & mask);
    if (sa >= longint'(half)) sa = sa - 2 * longint'(half);
    se   = longint'(be);
    if (se >= longint'(half)) se = se - 2 * longint'(half);
    r    = sa + se + longint'(c);
    ro   = (r >= longint'(half)) || (r < -longint'(half));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle on the 16-bit DUT: drive at negedge, sample, scoreboard handshakes, then the edge.
  task automatic applyStimulus(input bit v, input logic [15:0] ta, input logic [15:0] tbv,
                               input bit tc, input bit ts, input bit ordy);
    exp_t            e;
    longint unsigned rs;
    bit              rc;
    bit              ro;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tbv;
    cin       = tc;
    sub       = ts;
    out_ready = ordy;
    #1;
    s_valid   = out_valid;
    s_sum     = sum;
    s_cout    = cout;
    s_ovf     = ovf;
    s_inready = in_ready;
    s_cons    = out_valid && out_ready;
    s_acc     = in_valid && in_ready;
    if (s_cons) begin
      checkOutput("result_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("sb_sum", sum, e.s);
        checkOutput("sb_cout", cout, e.c);
        checkOutput("sb_ovf", ovf, e.o);
      end
      outCount++;
    end
    if (s_acc) begin
      model(16, ta, tbv, tc, ts, rs, rc, ro);
      e.s = rs[15:0];
      e.c = rc;
      e.o = ro;
      q.push_back(e);
      accCount++;
    end
    @(posedge clk);
  endtask

  task automatic waitResult(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (s_valid) ok = 1'b1;
    end
    checkOutput(tag, ok, 1);
  endtask

  initial begin
    int              nexti;
    int              got;
    int              stall;
    int              gaps;
    bit              ordy;
    int              acc0;
    int              out0;
    logic [15:0]     ra;
    logic [7:0]      ta8;
    logic [7:0]      tb8;
    bit              tc8;
    bit              ts8;
    longint unsigned rs;
    bit              rc;
    bit              ro;
    logic [7:0]      e8s[6];
    bit              e8c[6];
    bit              e8o[6];

    errors = 0; checks = 0; accCount = 0; outCount = 0;
    rst_n = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

    // Reset state, observed before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_out_valid8", out_valid8, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 0x0001 + 0xFFFF: wrap to zero with carry out, result present for exactly one cycle.
    applyStimulus(1'b1, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    checkOutput("wrap_accept", s_acc, 1);
    for (int i = 0; i < LAT + 2; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("wrap_latency_valid", s_valid, (i == LAT - 1));
      if (i == LAT - 1) begin
        checkOutput("wrap_sum", s_sum, 16'h0000);
        checkOutput("wrap_cout", s_cout, 1);
        checkOutput("wrap_ovf", s_ovf, 0);
      end
    end

    // Signed overflow on add, then a subtract that borrows.
    applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    waitResult("ovf_add_timeout");
    checkOutput("ovf_add_sum", s_sum, 16'h8000);
    checkOutput("ovf_add_cout", s_cout, 0);
    checkOutput("ovf_add_ovf", s_ovf, 1);
    applyStimulus(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    waitResult("sub_timeout");
    checkOutput("sub_sum", s_sum, 16'hFFFE);
    checkOutput("sub_cout", s_cout, 0);
    checkOutput("sub_ovf", s_ovf, 0);

    // Back-to-back beats with a three-cycle stall while the second result is presented.
    nexti = 1; got = 0; stall = 0; gaps = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      ordy = !(got == 1 && stall < 3);
      applyStimulus(nexti <= 8, 16'(nexti), 16'h1000, 1'b0, 1'b0, ordy);
      if (!ordy) begin
        stall++;
        checkOutput("stall_in_ready", s_inready, 0);
        checkOutput("stall_hold_valid", s_valid, 1);
        checkOutput("stall_hold_sum", s_sum, 16'h1002);
      end
      if (s_acc) nexti++;
      if (s_cons) begin
        got++;
        checkOutput("b2b_order", s_sum, 16'h1000 + got);
      end else if (ordy && got >= 1) begin
        gaps++;
      end
    end
    checkOutput("b2b_count", got, 8);
    checkOutput("b2b_gaps", gaps, 0);

    // Reset with beats in flight: immediate clear, nothing stale afterwards, first edge accepts.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_cout", cout, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    accCount = accCount - q.size();
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    checkOutput("post_rst_accept", s_acc, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("post_rst_valid", s_valid, (i == LAT - 1));
      if (i == LAT - 1) checkOutput("post_rst_sum", s_sum, 16'h0005);
    end

    // Single-stage 8-bit instance: one-cycle latency, one beat per cycle.
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      checkOutput("w8_in_ready", in_ready8, 1);
      if (j > 0) begin
        checkOutput("w8_valid", out_valid8, 1);
        checkOutput("w8_sum", sum8, e8s[j-1]);
        checkOutput("w8_cout", cout8, e8c[j-1]);
        checkOutput("w8_ovf", ovf8, e8o[j-1]);
        if (j == 1) begin
          checkOutput("w8_ff01_sum", sum8, 8'h01);
          checkOutput("w8_ff01_cout", cout8, 1);
          checkOutput("w8_ff01_ovf", ovf8, 0);
        end
      end else begin
        checkOutput("w8_idle_valid", out_valid8, 0);
      end
      if (j < 6) begin
        ta8 = (j == 0) ? 8'hFF : 8'($urandom);
        tb8 = (j == 0) ? 8'h01 : 8'($urandom);
        tc8 = (j == 0) ? 1'b1 : 1'($urandom);
        ts8 = (j == 0) ? 1'b0 : 1'($urandom);
        in_valid8 = 1'b1; a8 = ta8; b8 = tb8; cin8 = tc8; sub8 = ts8;
        model(8, ta8, tb8, tc8, ts8, rs, rc, ro);
        e8s[j] = rs[7:0];
        e8c[j] = rc;
        e8o[j] = ro;
      end else begin
        in_valid8 = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("w8_drained", out_valid8, 0);

    // Random traffic with random handshakes, operand corners mixed in.
    checkOutput("rand_start_empty", q.size(), 0);
    acc0 = accCount;
    out0 = outCount;
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        2:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, ra, 16'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("rand_drained", q.size(), 0);
    checkOutput("rand_count", outCount - out0, accCount - acc0);
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("rand_no_extra", s_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
